// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the UART command responder.
package uart_pkg;

    // Command bytes accepted from the host
    localparam logic [7:0] CMD_READ = 8'h52;
    localparam logic [7:0] CMD_ZERO = 8'h5A;
    localparam logic [7:0] CMD_PING = 8'h50;

    // Response bytes sent back to the host
    localparam logic [7:0] HDR = 8'hAA;
    localparam logic [7:0] ACK = 8'h06;
    localparam logic [7:0] NAK = 8'h15;

    // State encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;
    localparam logic [1:0] ST_WAIT = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        LOAD = ST_LOAD,
        SEND = ST_SEND,
        WAIT = ST_WAIT
    } state_e;

    // Single-byte answer for every command that is not a count read
    function automatic logic [7:0] short_reply(input logic [7:0] cmd);
        return ((cmd == CMD_ZERO) || (cmd == CMD_PING)) ? ACK : NAK;
    endfunction

endpackage

// File: rtl/uart_byte_sender.sv
// Hands one byte to the UART transmitter and waits for it to finish,
// giving up after TIMEOUT_CYCLES cycles (the load cycle counts as the first).
//
// state | meaning
// IDLE  | no byte in flight, waiting for load
// SEND  | byte latched, waiting for the UART to be free, then pulse tx_start
// WAIT  | tx_start issued, waiting for tx_done
module uart_byte_sender
    import uart_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 2_000_000,
    parameter int TO_W           = 21
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] byte_in,
    input  logic       tx_busy,
    input  logic       tx_done,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       byte_ok,
    output logic       byte_timeout
);

    // Loaded at the load edge; terminal count 0 lands on the last allowed cycle
    localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYCLES - 2);

    state_e          state_q, state_d;
    logic [7:0]      data_q, data_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            to_tc;

    assign to_tc   = (to_cnt_q == '0);
    assign tx_data = data_q;

    // State, held byte and timeout counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            data_q   <= '0;
            to_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            to_cnt_q <= to_cnt_d;
        end
    end

    // Handshake sequencing; timeout wins over a start in the same cycle
    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        to_cnt_d     = to_cnt_q;
        tx_start     = 1'b0;
        byte_ok      = 1'b0;
        byte_timeout = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (load) begin
                    data_d   = byte_in;
                    to_cnt_d = TO_LOAD;
                    state_d  = SEND;
                end
            end
            SEND: begin
                if (to_tc) begin
                    byte_timeout = 1'b1;
                    state_d      = IDLE;
                end else begin
                    to_cnt_d = to_cnt_q - TO_W'(1);
                    if (!tx_busy) begin
                        tx_start = 1'b1;
                        state_d  = WAIT;
                    end
                end
            end
            WAIT: begin
                if (tx_done) begin
                    byte_ok = 1'b1;
                    state_d = IDLE;
                end else if (to_tc) begin
                    byte_timeout = 1'b1;
                    state_d      = IDLE;
                end else begin
                    to_cnt_d = to_cnt_q - TO_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/uart_cmd_responder.sv
// Decodes host command bytes and answers with a framed count snapshot,
// ACK or NAK through the byte sender.
//
// state | meaning
// IDLE  | waiting for a command byte
// LOAD  | hand byte idx to the sender
// SEND  | sender waiting for the UART to accept the byte
// WAIT  | byte on the wire, waiting for tx_done (or timeout)
module uart_cmd_responder
    import uart_pkg::*;
#(
    parameter int COUNT_BYTES    = 4,
    parameter int TIMEOUT_CYCLES = 2_000_000,
    parameter int TO_W           = 21
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx_valid,
    input  logic [7:0]               rx_data,
    input  logic                     rx_error,
    input  logic                     tx_busy,
    input  logic                     tx_done,
    output logic                     tx_start,
    output logic [7:0]               tx_data,
    input  logic [8*COUNT_BYTES-1:0] count_in,
    output logic                     count_clear,
    output logic                     busy,
    output logic                     err_sticky,
    output logic                     cmd_dropped
);

    localparam int CW    = 8 * COUNT_BYTES;
    localparam int IDX_W = $clog2(COUNT_BYTES + 2);

    state_e           state_q, state_d;
    logic [CW-1:0]    shadow_q, shadow_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             is_read_q, is_read_d;
    logic [7:0]       reply_q, reply_d;
    logic             count_clear_q, count_clear_d;
    logic             err_q, err_d;
    logic             dropped_q, dropped_d;

    logic             load;
    logic [7:0]       byte_sel;
    logic [7:0]       checksum;
    logic             last_byte;
    logic             byte_ok;
    logic             byte_timeout;

    assign busy        = (state_q != IDLE);
    assign count_clear = count_clear_q;
    assign err_sticky  = err_q;
    assign cmd_dropped = dropped_q;
    assign last_byte   = is_read_q ? (idx_q == IDX_W'(COUNT_BYTES + 1)) : 1'b1;

    uart_byte_sender #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TO_W           (TO_W)
    ) u_sender (
        .clk          (clk),
        .rst          (rst),
        .load         (load),
        .byte_in      (byte_sel),
        .tx_busy      (tx_busy),
        .tx_done      (tx_done),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .byte_ok      (byte_ok),
        .byte_timeout (byte_timeout)
    );

    // Checksum is the XOR of the snapshot bytes
    always_comb begin
        checksum = '0;
        for (int b = 0; b < COUNT_BYTES; b++) begin
            checksum = checksum ^ shadow_q[8*b +: 8];
        end
    end

    // Frame byte for the current index: header, data MSB first, checksum
    always_comb begin
        byte_sel = reply_q;
        if (is_read_q) begin
            byte_sel = (idx_q == '0) ? HDR : checksum;
            for (int b = 0; b < COUNT_BYTES; b++) begin
                if (idx_q == IDX_W'(b + 1)) begin
                    byte_sel = shadow_q[8*(COUNT_BYTES-1-b) +: 8];
                end
            end
        end
    end

    // Responder state and frame context registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            shadow_q      <= '0;
            idx_q         <= '0;
            is_read_q     <= 1'b0;
            reply_q       <= '0;
            count_clear_q <= 1'b0;
            err_q         <= 1'b0;
            dropped_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            shadow_q      <= shadow_d;
            idx_q         <= idx_d;
            is_read_q     <= is_read_d;
            reply_q       <= reply_d;
            count_clear_q <= count_clear_d;
            err_q         <= err_d;
            dropped_q     <= dropped_d;
        end
    end

    // Command decode and frame sequencing
    always_comb begin
        state_d       = state_q;
        shadow_d      = shadow_q;
        idx_d         = idx_q;
        is_read_d     = is_read_q;
        reply_d       = reply_q;
        count_clear_d = 1'b0;
        err_d         = err_q | rx_error;
        dropped_d     = dropped_q | (rx_valid && (state_q != IDLE));
        load          = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    is_read_d     = (rx_data == CMD_READ);
                    reply_d       = short_reply(rx_data);
                    count_clear_d = (rx_data == CMD_ZERO);
                    idx_d         = '0;
                    if (rx_data == CMD_READ) begin
                        shadow_d = count_in;
                    end
                    state_d = LOAD;
                end
            end
            LOAD: begin
                load    = 1'b1;
                state_d = SEND;
            end
            SEND: begin
                if (byte_timeout) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (tx_start) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (byte_ok) begin
                    if (last_byte) begin
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = LOAD;
                    end
                end else if (byte_timeout) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Bench for uart_cmd_responder: a simple UART transmitter model logs every
// started byte and frames are compared against a queue built from the
// command rules.
module tb_uart_cmd_responder;

    localparam int CB = 4;
    localparam int TO = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_error = 1'b0;
    logic        tx_busy = 1'b0;
    logic        tx_done = 1'b0;
    logic [31:0] count_in = 32'h0;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        count_clear;
    logic        busy;
    logic        err_sticky;
    logic        cmd_dropped;

    int total = 0;
    int bad   = 0;

    byte unsigned tx_log[$];
    byte unsigned exp_q[$];

    int         starts    = 0;
    bit         m_pending = 1'b0;
    bit         m_stall   = 1'b0;
    bit         m_abandon = 1'b0;
    int         m_bits    = 0;
    logic [7:0] m_cur     = 8'h00;
    longint     m_done_t  = 0;

    uart_cmd_responder #(
        .COUNT_BYTES    (CB),
        .TIMEOUT_CYCLES (TO),
        .TO_W           (21)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_error    (rx_error),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .count_in    (count_in),
        .count_clear (count_clear),
        .busy        (busy),
        .err_sticky  (err_sticky),
        .cmd_dropped (cmd_dropped)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // UART transmitter model: busy a few cycles after each start, then tx_done
    always @(negedge clk) begin
        logic st;
        st      = tx_start;
        tx_done = 1'b0;
        if (m_pending) begin
            m_pending = 1'b0;
            tx_busy   = 1'b1;
            m_bits    = $urandom_range(1, 5);
        end else if (tx_busy && !m_stall) begin
            if (m_bits == 0) begin
                tx_busy  = 1'b0;
                tx_done  = 1'b1;
                m_done_t = longint'($time);
                if (!m_abandon) check("tx_data_hold", 32'(tx_data), 32'(m_cur));
            end else begin
                m_bits--;
            end
        end
        if (st === 1'b1) begin
            tx_log.push_back(tx_data);
            m_cur     = tx_data;
            m_abandon = 1'b0;
            starts++;
            m_pending = 1'b1;
        end
    end

    function automatic void build_expected(input logic [7:0] cmd, input logic [31:0] cnt);
        byte unsigned cs;
        cs = 8'h00;
        exp_q.delete();
        if (cmd == 8'h52) begin
            exp_q.push_back(8'hAA);
            for (int i = CB - 1; i >= 0; i--) begin
                byte unsigned b;
                b = 8'(cnt >> (8 * i));
                exp_q.push_back(b);
                cs = cs ^ b;
            end
            exp_q.push_back(cs);
        end else if (cmd == 8'h5A || cmd == 8'h50) begin
            exp_q.push_back(8'h06);
        end else begin
            exp_q.push_back(8'h15);
        end
    endfunction

    task automatic send_rx(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle"}, 32'(busy), 32'(0));
        check({tag, "_busy_tail"}, 32'(longint'($time) - m_done_t), 32'(10));
    endtask

    task automatic expect_frame(input string tag);
        check({tag, "_len"}, 32'(tx_log.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            logic [7:0] got;
            got = (i < tx_log.size()) ? tx_log[i] : 8'hxx;
            check($sformatf("%s_b%0d", tag, i), 32'(got), 32'(exp_q[i]));
        end
    endtask

    task automatic run_cmd(input logic [7:0] cmd, input string tag);
        logic [31:0] snap;
        snap = count_in;
        tx_log.delete();
        send_rx(cmd);
        check({tag, "_clr_n1"}, 32'(count_clear), 32'(cmd == 8'h5A));
        @(negedge clk);
        check({tag, "_start_n2"}, 32'(tx_start), 32'(1));
        check({tag, "_clr_n2"}, 32'(count_clear), 32'(0));
        count_in = $urandom();
        wait_idle(tag);
        build_expected(cmd, snap);
        expect_frame(tag);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int n;
        logic [31:0] cnt_b;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_tx_start", 32'(tx_start), 32'(0));
        check("rst_tx_data", 32'(tx_data), 32'(0));
        check("rst_count_clear", 32'(count_clear), 32'(0));
        check("rst_err", 32'(err_sticky), 32'(0));
        check("rst_dropped", 32'(cmd_dropped), 32'(0));
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Directed commands
        count_in = 32'h12345678;
        run_cmd(8'h52, "read");
        run_cmd(8'h5A, "zero");
        run_cmd(8'h50, "ping");
        run_cmd(8'h41, "nak");

        // Second command while the first answer is in flight is dropped
        check("drop_before", 32'(cmd_dropped), 32'(0));
        tx_log.delete();
        send_rx(8'h50);
        @(negedge clk);
        send_rx(8'h50);
        check("drop_flag", 32'(cmd_dropped), 32'(1));
        wait_idle("drop");
        build_expected(8'h50, 32'h0);
        expect_frame("drop");

        // Randomized command mix
        for (int k = 0; k < 10; k++) begin
            logic [7:0] cmd;
            case ($urandom_range(0, 3))
                0: cmd = 8'h52;
                1: cmd = 8'h5A;
                2: cmd = 8'h50;
                default: cmd = 8'($urandom_range(0, 255));
            endcase
            count_in = $urandom();
            run_cmd(cmd, $sformatf("rnd%0d", k));
        end

        // rx_error in IDLE: flag only
        check("rxerr_before", 32'(err_sticky), 32'(0));
        s0 = starts;
        @(negedge clk);
        rx_error = 1'b1;
        @(negedge clk);
        rx_error = 1'b0;
        check("rxerr_flag", 32'(err_sticky), 32'(1));
        check("rxerr_busy", 32'(busy), 32'(0));
        repeat (5) @(negedge clk);
        check("rxerr_no_start", 32'(starts), 32'(s0));

        // Asynchronous reset during the third byte of a read frame
        s0 = starts;
        tx_log.delete();
        count_in = 32'hCAFEF00D;
        send_rx(8'h52);
        n = 0;
        while (starts < s0 + 3 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("rst_mid_reached", 32'(starts), 32'(s0 + 3));
        #2 rst = 1'b1;
        m_abandon = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 32'(0));
        check("arst_tx_start", 32'(tx_start), 32'(0));
        check("arst_tx_data", 32'(tx_data), 32'(0));
        check("arst_count_clear", 32'(count_clear), 32'(0));
        check("arst_err", 32'(err_sticky), 32'(0));
        check("arst_dropped", 32'(cmd_dropped), 32'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        cnt_b = $urandom();
        count_in = cnt_b;
        tx_log.delete();
        send_rx(8'h52);
        wait_idle("rst_read");
        build_expected(8'h52, cnt_b);
        expect_frame("rst_read");

        // Stalled UART: timeout after TO cycles counted from LOAD
        check("to_err_before", 32'(err_sticky), 32'(0));
        m_stall = 1'b1;
        s0 = starts;
        tx_log.delete();
        send_rx(8'h50);
        repeat (TO - 1) @(negedge clk);
        check("to_busy_last", 32'(busy), 32'(1));
        @(negedge clk);
        check("to_idle", 32'(busy), 32'(0));
        check("to_err", 32'(err_sticky), 32'(1));
        check("to_one_start", 32'(starts), 32'(s0 + 1));
        repeat (20) @(negedge clk);
        check("to_no_more_start", 32'(starts), 32'(s0 + 1));
        m_stall = 1'b0;
        n = 0;
        while (tx_busy !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("to_uart_free", 32'(tx_busy), 32'(0));
        @(negedge clk);
        run_cmd(8'h50, "after_to");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
